// File: rtl/uart_pkg.sv
// Shared types for the configurable UART receiver: FSM state enum, parity modes, parity check.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StStop2,
        StWaitHigh
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // data_xor is the XOR of all data bits; returns 1 when the received parity bit is consistent.
    function automatic logic parity_ok(input logic [1:0] mode, input logic data_xor,
                                       input logic par_bit);
        return (mode == PAR_ODD) ? (data_xor ^ par_bit) : !(data_xor ^ par_bit);
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// AXI-stream style output channel of the UART receiver (data, valid, ready).
interface uart_rx_cfg_if #(
    parameter int unsigned G_DATAWIDTH = 8
);
    logic [G_DATAWIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_rx_sampler.sv
// Two-flop rxd synchroniser; with UART_RX_MAJORITY_EN defined, adds a 2-of-3 voter over the
// last three synchronised values so a sample taken at counter 0 covers counter values 2,1,0.
module uart_rx_sampler (
    input  logic clk,
    input  logic rst,
    input  logic i_rxd,
    output logic o_rxd_sync,
    output logic o_bit
);
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
        end
    end

    assign o_rxd_sync = r_sync2;

`ifdef UART_RX_MAJORITY_EN
    logic r_hist1;
    logic r_hist2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist1 <= 1'b1;
            r_hist2 <= 1'b1;
        end else begin
            r_hist1 <= r_sync2;
            r_hist2 <= r_hist1;
        end
    end

    assign o_bit = (r_hist1 & r_hist2) | (r_hist1 & r_sync2) | (r_hist2 & r_sync2);
`else
    assign o_bit = r_sync2;
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with runtime prescale/parity/stop-bit config and a backpressured stream output.
// Optional macro UART_RX_MAJORITY_EN selects 2-of-3 majority sampling in uart_rx_sampler.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned G_DATAWIDTH  = 8,
    parameter int unsigned G_PRESCALE_W = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_rxd,
    input  logic [G_PRESCALE_W-1:0] i_cfg_prescale,
    input  logic [1:0]              i_cfg_parity,
    input  logic                    i_cfg_stop2,
    uart_rx_cfg_if.master           m_axis,
    output logic                    o_busy,
    output logic                    o_frame_error,
    output logic                    o_parity_error,
    output logic                    o_overrun_error,
    output logic                    o_break_detect
);
    localparam int unsigned BitCntW = (G_DATAWIDTH > 1) ? $clog2(G_DATAWIDTH) : 1;

    rx_state_e               r_state;
    logic [G_PRESCALE_W-1:0] r_prescale;
    logic [G_PRESCALE_W-1:0] r_cnt;
    logic [BitCntW-1:0]      r_bit_cnt;
    logic [G_DATAWIDTH-1:0]  r_shift;
    logic [1:0]              r_parity;
    logic                    r_stop2;
    logic                    r_par_bit;
    logic                    r_stop_bad;

    logic                    w_rxd_sync;
    logic                    w_bit;
    logic [G_PRESCALE_W-1:0] w_prescale_eff;
    logic                    w_tick;
    logic                    w_par_en;
    logic                    w_last_stop;
    logic                    w_frame_bad;
    logic                    w_par_bad;
    logic                    w_stop1_zero;
    logic                    w_break;

    uart_rx_sampler u_sampler (
        .clk        (clk),
        .rst        (rst),
        .i_rxd      (i_rxd),
        .o_rxd_sync (w_rxd_sync),
        .o_bit      (w_bit)
    );

    always_comb begin
        w_prescale_eff = (i_cfg_prescale < G_PRESCALE_W'(8)) ? G_PRESCALE_W'(8) : i_cfg_prescale;
        w_tick         = (r_cnt == '0);
        w_par_en       = (r_parity == PAR_EVEN) || (r_parity == PAR_ODD);
        w_last_stop    = w_tick && (((r_state == StStop) && !r_stop2) || (r_state == StStop2));
        w_frame_bad    = r_stop_bad || !w_bit;
        w_par_bad      = w_par_en && !parity_ok(r_parity, ^r_shift, r_par_bit);
        // First stop bit is either being sampled now or was recorded on the previous sample.
        w_stop1_zero   = (r_state == StStop) ? !w_bit : r_stop_bad;
        w_break        = (r_shift == '0) && (!w_par_en || !r_par_bit) && w_stop1_zero;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= StIdle;
            r_prescale      <= '0;
            r_cnt           <= '0;
            r_bit_cnt       <= '0;
            r_shift         <= '0;
            r_parity        <= PAR_NONE;
            r_stop2         <= 1'b0;
            r_par_bit       <= 1'b0;
            r_stop_bad      <= 1'b0;
            m_axis.tdata    <= '0;
            m_axis.tvalid   <= 1'b0;
            o_busy          <= 1'b0;
            o_frame_error   <= 1'b0;
            o_parity_error  <= 1'b0;
            o_overrun_error <= 1'b0;
            o_break_detect  <= 1'b0;
        end else begin
            o_frame_error   <= 1'b0;
            o_parity_error  <= 1'b0;
            o_overrun_error <= 1'b0;
            o_break_detect  <= 1'b0;
            if (m_axis.tvalid && m_axis.tready) begin
                m_axis.tvalid <= 1'b0;
            end

            case (r_state)
                StIdle: begin
                    if (!w_rxd_sync) begin
                        r_state    <= StStart;
                        o_busy     <= 1'b1;
                        r_prescale <= w_prescale_eff;
                        r_cnt      <= (w_prescale_eff >> 1) - G_PRESCALE_W'(1);
                        r_parity   <= (i_cfg_parity == 2'b11) ? PAR_NONE : i_cfg_parity;
                        r_stop2    <= i_cfg_stop2;
                        r_bit_cnt  <= '0;
                        r_par_bit  <= 1'b0;
                        r_stop_bad <= 1'b0;
                    end
                end
                StStart: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - G_PRESCALE_W'(1);
                    end else if (!w_bit) begin
                        r_state <= StData;
                        r_cnt   <= r_prescale - G_PRESCALE_W'(1);
                    end else begin
                        r_state <= StIdle;
                        o_busy  <= 1'b0;
                    end
                end
                StData: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - G_PRESCALE_W'(1);
                    end else begin
                        r_shift   <= {w_bit, r_shift[G_DATAWIDTH-1:1]};
                        r_bit_cnt <= r_bit_cnt + BitCntW'(1);
                        r_cnt     <= r_prescale - G_PRESCALE_W'(1);
                        if (r_bit_cnt == BitCntW'(G_DATAWIDTH - 1)) begin
                            r_state <= w_par_en ? StParity : StStop;
                        end
                    end
                end
                StParity: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - G_PRESCALE_W'(1);
                    end else begin
                        r_par_bit <= w_bit;
                        r_cnt     <= r_prescale - G_PRESCALE_W'(1);
                        r_state   <= StStop;
                    end
                end
                StStop: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - G_PRESCALE_W'(1);
                    end else if (r_stop2) begin
                        r_stop_bad <= !w_bit;
                        r_cnt      <= r_prescale - G_PRESCALE_W'(1);
                        r_state    <= StStop2;
                    end
                end
                StStop2: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - G_PRESCALE_W'(1);
                    end
                end
                StWaitHigh: begin
                    if (w_rxd_sync) begin
                        r_state <= StIdle;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    o_busy  <= 1'b0;
                end
            endcase

            // Completion is evaluated on the final stop sample so outputs appear the next cycle.
            if (w_last_stop) begin
                o_frame_error  <= w_frame_bad;
                o_parity_error <= w_par_bad;
                o_break_detect <= w_frame_bad && w_break;
                if (!w_frame_bad && !w_par_bad) begin
                    if (m_axis.tvalid && !m_axis.tready) begin
                        o_overrun_error <= 1'b1;
                    end else begin
                        m_axis.tdata  <= r_shift;
                        m_axis.tvalid <= 1'b1;
                    end
                end
                r_state <= w_frame_bad ? StWaitHigh : StIdle;
                o_busy  <= w_frame_bad;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed frames plus randomized frames against a
// frame-level reference model of expected delivery and error pulses.
module tb_uart_rx_cfg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic [18:0] cfg_prescale = 19'd16;
    logic [1:0]  cfg_parity = 2'b00;
    logic        cfg_stop2 = 1'b0;
    logic        busy;
    logic        frame_error;
    logic        parity_error;
    logic        overrun_error;
    logic        break_detect;

    uart_rx_cfg_if #(.G_DATAWIDTH(8)) m_axis ();

    uart_rx_cfg #(
        .G_DATAWIDTH  (8),
        .G_PRESCALE_W (19)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_rxd           (rxd),
        .i_cfg_prescale  (cfg_prescale),
        .i_cfg_parity    (cfg_parity),
        .i_cfg_stop2     (cfg_stop2),
        .m_axis          (m_axis),
        .o_busy          (busy),
        .o_frame_error   (frame_error),
        .o_parity_error  (parity_error),
        .o_overrun_error (overrun_error),
        .o_break_detect  (break_detect)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    int       n_words = 0;
    int       n_fe = 0;
    int       n_pe = 0;
    int       n_ov = 0;
    int       n_brk = 0;
    int       n_unstable = 0;
    logic [7:0] last_word = 8'h00;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;

    // Event counters; a pulse wider than one cycle shows up as an extra count.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_error)   n_fe  <= n_fe + 1;
            if (parity_error)  n_pe  <= n_pe + 1;
            if (overrun_error) n_ov  <= n_ov + 1;
            if (break_detect)  n_brk <= n_brk + 1;
            if (m_axis.tvalid && m_axis.tready) begin
                n_words   <= n_words + 1;
                last_word <= m_axis.tdata;
            end
            if (prev_valid && !prev_ready && m_axis.tvalid && (m_axis.tdata != prev_data)) begin
                n_unstable <= n_unstable + 1;
            end
        end
        prev_valid <= m_axis.tvalid;
        prev_ready <= m_axis.tready;
        prev_data  <= m_axis.tdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [7:0] d, input logic [1:0] pm, input bit st2,
                                  input bit pb, input bit s1, input bit s2, output bit ok,
                                  output bit fe, output bit pe, output bit brk);
        bit pen;
        bit want;
        int ones;
        pen  = (pm == 2'd1) || (pm == 2'd2);
        ones = $countones(d);
        want = (pm == 2'd1) ? (ones % 2 == 1) : (ones % 2 == 0);
        fe   = !s1 || (st2 && !s2);
        pe   = pen && (pb != want);
        brk  = fe && !s1 && (d == 8'h00) && (!pen || !pb);
        ok   = !fe && !pe;
    endfunction

    task automatic drive_bit(input bit b, input int p);
        rxd = b;
        repeat (p) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input bit has_par, input bit pb,
                              input bit s1, input bit has_s2, input bit s2, input bit scramble);
        drive_bit(1'b0, p);
        if (scramble) begin
            cfg_prescale = 19'($urandom);
            cfg_parity   = 2'($urandom);
            cfg_stop2    = 1'($urandom);
        end
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (has_par) drive_bit(pb, p);
        drive_bit(s1, p);
        if (has_s2) drive_bit(s2, p);
        rxd = 1'b1;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input int pcfg,
                             input logic [1:0] pm, input bit st2, input bit pb, input bit s1,
                             input bit s2, input bit scramble);
        int p;
        int w0, fe0, pe0, ov0, br0;
        bit ok, efe, epe, ebrk;
        p = (pcfg < 8) ? 8 : pcfg;
        cfg_prescale = 19'(pcfg);
        cfg_parity   = pm;
        cfg_stop2    = st2;
        repeat (2) @(negedge clk);
        w0 = n_words; fe0 = n_fe; pe0 = n_pe; ov0 = n_ov; br0 = n_brk;
        send_frame(d, p, (pm == 2'd1) || (pm == 2'd2), pb, s1, st2, s2, scramble);
        repeat (3 * p) @(negedge clk);
        model(d, pm, st2, pb, s1, s2, ok, efe, epe, ebrk);
        check_eq($sformatf("%s words", tag), 32'(n_words - w0), 32'(ok));
        if (ok) check_eq($sformatf("%s data", tag), 32'(last_word), 32'(d));
        check_eq($sformatf("%s frame_err", tag), 32'(n_fe - fe0), 32'(efe));
        check_eq($sformatf("%s parity_err", tag), 32'(n_pe - pe0), 32'(epe));
        check_eq($sformatf("%s break", tag), 32'(n_brk - br0), 32'(ebrk));
        check_eq($sformatf("%s overrun", tag), 32'(n_ov - ov0), 32'd0);
        check_eq($sformatf("%s busy_idle", tag), 32'(busy), 32'd0);
    endtask

    initial begin
        int w0, fe0, pe0, ov0, br0;
        m_axis.tready = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("rst tvalid", 32'(m_axis.tvalid), 32'd0);
        check_eq("rst tdata", 32'(m_axis.tdata), 32'd0);
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst pulses", 32'({frame_error, parity_error, overrun_error, break_detect}),
                 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        run_frame("a5_8n1", 8'hA5, 16, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_frame("even_ok", 8'h37, 16, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        run_frame("even_bad", 8'h37, 16, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_frame("stop2_bad", 8'hC3, 16, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_frame("clamp", 8'h3C, 3, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        // Backpressure: second word must be dropped with one overrun pulse.
        cfg_prescale = 19'd16; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        m_axis.tready = 1'b0;
        w0 = n_words; ov0 = n_ov; fe0 = n_fe;
        send_frame(8'h11, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (32) @(negedge clk);
        send_frame(8'h22, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (32) @(negedge clk);
        check_eq("ovr tdata", 32'(m_axis.tdata), 32'h11);
        check_eq("ovr tvalid", 32'(m_axis.tvalid), 32'd1);
        check_eq("ovr pulse", 32'(n_ov - ov0), 32'd1);
        m_axis.tready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("ovr words", 32'(n_words - w0), 32'd1);
        check_eq("ovr word", 32'(last_word), 32'h11);
        check_eq("ovr tvalid_fall", 32'(m_axis.tvalid), 32'd0);
        check_eq("ovr no_fe", 32'(n_fe - fe0), 32'd0);

        // Reset in the middle of the data bits aborts silently.
        w0 = n_words; fe0 = n_fe; pe0 = n_pe; ov0 = n_ov; br0 = n_brk;
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 8);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("mid_rst tvalid", 32'(m_axis.tvalid), 32'd0);
        check_eq("mid_rst tdata", 32'(m_axis.tdata), 32'd0);
        check_eq("mid_rst busy", 32'(busy), 32'd0);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (48) @(negedge clk);
        check_eq("mid_rst events", 32'((n_words - w0) + (n_fe - fe0) + (n_pe - pe0) +
                 (n_ov - ov0) + (n_brk - br0)), 32'd0);
        run_frame("after_rst", 8'h5A, 16, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Long low line: one frame error with break, no restart while the line stays low.
        cfg_prescale = 19'd16; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        w0 = n_words; fe0 = n_fe; br0 = n_brk;
        rxd = 1'b0;
        repeat (192) @(negedge clk);
        check_eq("brk fe", 32'(n_fe - fe0), 32'd1);
        check_eq("brk pulse", 32'(n_brk - br0), 32'd1);
        check_eq("brk busy_low", 32'(busy), 32'd1);
        rxd = 1'b1;
        repeat (48) @(negedge clk);
        check_eq("brk busy_end", 32'(busy), 32'd0);
        check_eq("brk fe_once", 32'(n_fe - fe0), 32'd1);
        check_eq("brk words", 32'(n_words - w0), 32'd0);

        // Short glitch on idle line.
        w0 = n_words; fe0 = n_fe; pe0 = n_pe; ov0 = n_ov; br0 = n_brk;
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("glitch busy_up", 32'(busy), 32'd1);
        repeat (14) @(negedge clk);
        check_eq("glitch busy_down", 32'(busy), 32'd0);
        check_eq("glitch events", 32'((n_words - w0) + (n_fe - fe0) + (n_pe - pe0) +
                 (n_ov - ov0) + (n_brk - br0)), 32'd0);
        check_eq("glitch tvalid", 32'(m_axis.tvalid), 32'd0);

        for (int k = 0; k < 30; k++) begin
            logic [7:0] d;
            logic [1:0] pm;
            int         pcfg;
            bit         st2, pb, s1, s2, want;
            pcfg = $urandom_range(4, 40);
            pm   = 2'($urandom_range(0, 3));
            st2  = 1'($urandom_range(0, 1));
            d    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            want = (pm == 2'd1) ? ($countones(d) % 2 == 1) : ($countones(d) % 2 == 0);
            pb   = want ^ ($urandom_range(0, 3) == 0);
            s1   = ($urandom_range(0, 5) != 0);
            s2   = ($urandom_range(0, 5) != 0);
            run_frame($sformatf("rnd%0d", k), d, pcfg, pm, st2, pb, s1, s2, 1'b1);
        end

        check_eq("tdata stable", 32'(n_unstable), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
